// File: rtl/ysyx_00000000_axi_pkg.sv
// Shared definitions for the AXI4 SRAM responder.
//   RESP_*   : AXI response codes driven on bresp/rresp
//   BURST_*  : AXI burst type encodings seen on awburst/arburst
//   r_state_e / w_state_e : read and write channel FSM states
//   byte_merge: byte-lane write helper used by the memory array
package ysyx_00000000_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_DATA = 2'd2
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  // Replace the byte lanes of old_word selected by strb with new_word.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int unsigned i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ysyx_00000000_axi_burst_addr.sv
// Per-beat address helper for one AXI channel (purely combinational).
//   addr/size/burst : address and attributes of the current beat
//   next_addr       : address of the following beat (INCR advances, else holds)
//   beat_err        : beat must answer SLVERR (out of range, WRAP/reserved
//                     burst, or size wider than the 32-bit bus)
module ysyx_00000000_axi_burst_addr
  import ysyx_00000000_axi_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr,
  output logic        beat_err
);

  localparam int unsigned AW = $clog2(MEM_BYTES);

  logic in_range;

  always_comb begin
    // BASE_ADDR is MEM_BYTES-aligned, so the range test is an upper-bit match.
    in_range  = (addr[31:AW] == BASE_ADDR[31:AW]);
    beat_err  = !in_range || (burst == BURST_WRAP) || (burst == 2'b11) ||
                (size > 3'd2);
    next_addr = addr;
    if ((burst == BURST_INCR) && (size <= 3'd2)) begin
      next_addr = addr + (32'd1 << size);
    end
  end

endmodule

// File: rtl/ysyx_00000000_axi_sram.sv
// AXI4 slave memory: byte-addressable register-array RAM with independent
// read and write channels, INCR/FIXED bursts, narrow transfers, byte strobes
// and READ_LATENCY wait states before every read beat.
//   clock/reset        : clock (posedge), asynchronous active-low reset
//   aw*/w*/b*          : write address, write data, write response channels
//   ar*/r*             : read address and read data channels
module ysyx_00000000_axi_sram
  import ysyx_00000000_axi_pkg::*;
#(
  parameter int unsigned MEM_BYTES    = 4096,
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
  parameter int unsigned READ_LATENCY = 0
) (
  input  logic        clock,
  input  logic        reset,
  // write address
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  // write data
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  // write response
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  output logic [3:0]  bid,
  // read address
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  // read data
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic [3:0]  rid
);

  localparam int unsigned AW    = $clog2(MEM_BYTES);
  localparam int unsigned WORDS = MEM_BYTES / 4;
  localparam logic [3:0]  LAT   = 4'(READ_LATENCY);

  logic [31:0] mem [WORDS];

  // ---------------------------------------------------------------- read side
  r_state_e    r_state_q, r_state_d;
  logic [31:0] r_addr_q,  r_addr_d;
  logic [7:0]  r_len_q,   r_len_d;
  logic [7:0]  r_beat_q,  r_beat_d;
  logic [2:0]  r_size_q,  r_size_d;
  logic [1:0]  r_burst_q, r_burst_d;
  logic [3:0]  r_id_q,    r_id_d;
  logic [3:0]  r_cnt_q,   r_cnt_d;
  logic        rvalid_q,  rvalid_d;
  logic        rlast_q,   rlast_d;
  logic [31:0] rdata_q,   rdata_d;
  logic [1:0]  rresp_q,   rresp_d;

  logic        r_ld;
  logic [31:0] rd_addr;
  logic [2:0]  rd_size;
  logic [1:0]  rd_burst;
  logic [31:0] rd_next;
  logic        rd_err;

  // r_addr_q always holds the address of the next beat to be loaded, so one
  // checker instance serves both the first beat (from araddr) and later beats.
  always_comb begin
    rd_addr  = r_addr_q;
    rd_size  = r_size_q;
    rd_burst = r_burst_q;
    if (r_state_q == R_IDLE) begin
      rd_addr  = araddr;
      rd_size  = arsize;
      rd_burst = arburst;
    end
  end

  ysyx_00000000_axi_burst_addr #(
    .MEM_BYTES (MEM_BYTES),
    .BASE_ADDR (BASE_ADDR)
  ) u_rd_addr (
    .addr      (rd_addr),
    .size      (rd_size),
    .burst     (rd_burst),
    .next_addr (rd_next),
    .beat_err  (rd_err)
  );

  always_comb begin
    r_state_d = r_state_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_beat_d  = r_beat_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    r_id_d    = r_id_q;
    r_cnt_d   = r_cnt_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    r_ld      = 1'b0;

    case (r_state_q)
      R_IDLE: begin
        if (arvalid) begin
          r_id_d    = arid;
          r_len_d   = arlen;
          r_size_d  = arsize;
          r_burst_d = arburst;
          r_addr_d  = araddr;
          r_beat_d  = '0;
          if (LAT == 4'd0) begin
            r_ld      = 1'b1;
            rlast_d   = (arlen == 8'd0);
            r_state_d = R_DATA;
          end else begin
            r_cnt_d   = LAT;
            r_state_d = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (r_cnt_q == 4'd1) begin
          r_ld      = 1'b1;
          rlast_d   = (r_beat_q == r_len_q);
          r_state_d = R_DATA;
        end else begin
          r_cnt_d = r_cnt_q - 4'd1;
        end
      end
      R_DATA: begin
        if (rready) begin
          rvalid_d = 1'b0;
          if (rlast_q) begin
            rlast_d   = 1'b0;
            r_state_d = R_IDLE;
          end else begin
            r_beat_d = r_beat_q + 8'd1;
            if (LAT == 4'd0) begin
              r_ld    = 1'b1;
              rlast_d = ((r_beat_q + 8'd1) == r_len_q);
            end else begin
              rlast_d   = 1'b0;
              r_cnt_d   = LAT;
              r_state_d = R_WAIT;
            end
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase

    // The beat is captured into output flops here, so a write landing on the
    // same edge is not visible and the payload stays stable under backpressure.
    if (r_ld) begin
      rvalid_d = 1'b1;
      r_addr_d = rd_next;
      rdata_d  = rd_err ? '0 : mem[rd_addr[AW-1:2]];
      rresp_d  = rd_err ? RESP_SLVERR : RESP_OKAY;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state_q <= R_IDLE;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_id_q    <= '0;
      r_cnt_q   <= '0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_beat_q  <= r_beat_d;
      r_size_q  <= r_size_d;
      r_burst_q <= r_burst_d;
      r_id_q    <= r_id_d;
      r_cnt_q   <= r_cnt_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign arready = (r_state_q == R_IDLE);
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rid     = r_id_q;

  // --------------------------------------------------------------- write side
  w_state_e    w_state_q, w_state_d;
  logic [31:0] w_addr_q,  w_addr_d;
  logic [7:0]  w_len_q,   w_len_d;
  logic [7:0]  w_beat_q,  w_beat_d;
  logic [2:0]  w_size_q,  w_size_d;
  logic [1:0]  w_burst_q, w_burst_d;
  logic [3:0]  w_id_q,    w_id_d;
  logic        w_err_q,   w_err_d;
  logic        bvalid_q,  bvalid_d;
  logic [1:0]  bresp_q,   bresp_d;

  logic        w_idle;
  logic        w_hs;
  logic        mem_we;
  logic [31:0] wr_addr;
  logic [2:0]  wr_size;
  logic [1:0]  wr_burst;
  logic [31:0] wr_next;
  logic        wr_err;
  logic [7:0]  w_cur_beat;
  logic [7:0]  w_cur_len;
  logic        w_err_acc;

  // In W_IDLE the first beat may be accepted together with the address, so
  // its attributes come straight from the AW payload.
  always_comb begin
    w_idle   = (w_state_q == W_IDLE);
    wr_addr  = w_idle ? awaddr  : w_addr_q;
    wr_size  = w_idle ? awsize  : w_size_q;
    wr_burst = w_idle ? awburst : w_burst_q;
  end

  ysyx_00000000_axi_burst_addr #(
    .MEM_BYTES (MEM_BYTES),
    .BASE_ADDR (BASE_ADDR)
  ) u_wr_addr (
    .addr      (wr_addr),
    .size      (wr_size),
    .burst     (wr_burst),
    .next_addr (wr_next),
    .beat_err  (wr_err)
  );

  always_comb begin
    w_state_d  = w_state_q;
    w_addr_d   = w_addr_q;
    w_len_d    = w_len_q;
    w_beat_d   = w_beat_q;
    w_size_d   = w_size_q;
    w_burst_d  = w_burst_q;
    w_id_d     = w_id_q;
    w_err_d    = w_err_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    w_hs       = 1'b0;
    mem_we     = 1'b0;
    w_cur_beat = w_beat_q;
    w_cur_len  = w_len_q;
    w_err_acc  = w_err_q;

    case (w_state_q)
      W_IDLE: begin
        if (awvalid) begin
          w_id_d     = awid;
          w_len_d    = awlen;
          w_size_d   = awsize;
          w_burst_d  = awburst;
          w_addr_d   = awaddr;
          w_beat_d   = '0;
          w_err_d    = 1'b0;
          w_state_d  = W_DATA;
          w_cur_beat = '0;
          w_cur_len  = awlen;
          w_err_acc  = 1'b0;
          w_hs       = wvalid;
        end
      end
      W_DATA: w_hs = wvalid;
      W_RESP: begin
        if (bready) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase

    if (w_hs) begin
      mem_we   = !wr_err;
      w_addr_d = wr_next;
      w_beat_d = w_cur_beat + 8'd1;
      w_err_d  = w_err_acc | wr_err;
      if (wlast) begin
        w_state_d = W_RESP;
        bvalid_d  = 1'b1;
        bresp_d   = (w_err_d || (w_cur_beat != w_cur_len)) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      w_state_q <= W_IDLE;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_beat_q  <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_id_q    <= '0;
      w_err_q   <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_beat_q  <= w_beat_d;
      w_size_q  <= w_size_d;
      w_burst_q <= w_burst_d;
      w_id_q    <= w_id_d;
      w_err_q   <= w_err_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[wr_addr[AW-1:2]] <= byte_merge(mem[wr_addr[AW-1:2]], wdata, wstrb);
    end
  end

  assign awready = w_idle;
  assign wready  = (w_idle && awvalid) || (w_state_q == W_DATA);
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign bid     = w_id_q;

endmodule

// File: tb/tb_ysyx_00000000_axi_sram.sv
`timescale 1ns/1ps
module tb_ysyx_00000000_axi_sram;

  localparam int LAT = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  always #5 clock = ~clock;

  ysyx_00000000_axi_sram #(
    .MEM_BYTES    (4096),
    .BASE_ADDR    (32'h8000_0000),
    .READ_LATENCY (LAT)
  ) dut (
    .clock   (clock),   .reset   (reset),
    .awvalid (awvalid), .awready (awready), .awaddr (awaddr), .awid (awid),
    .awlen   (awlen),   .awsize  (awsize),  .awburst (awburst),
    .wvalid  (wvalid),  .wready  (wready),  .wdata  (wdata),  .wstrb (wstrb),
    .wlast   (wlast),
    .bvalid  (bvalid),  .bready  (bready),  .bresp  (bresp),  .bid   (bid),
    .arvalid (arvalid), .arready (arready), .araddr (araddr), .arid  (arid),
    .arlen   (arlen),   .arsize  (arsize),  .arburst (arburst),
    .rvalid  (rvalid),  .rready  (rready),  .rdata  (rdata),  .rresp (rresp),
    .rlast   (rlast),   .rid     (rid)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rexp_t;

  typedef struct packed {
    logic [1:0] resp;
    logic [3:0] id;
  } bexp_t;

  rexp_t r_q[$];
  bexp_t b_q[$];
  int    n_checks = 0;
  int    n_errs   = 0;
  int    rr_mode  = 0;   // 0: rready high, 1: toggling, 2: rready low

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void push_r(input logic [31:0] d, input logic [1:0] resp,
                                 input logic last, input logic [3:0] id);
    rexp_t e;
    e.data = d; e.resp = resp; e.last = last; e.id = id;
    r_q.push_back(e);
  endfunction

  // rready driver
  initial begin
    rready = 1'b0;
    forever begin
      @(posedge clock); #1;
      case (rr_mode)
        0:       rready = 1'b1;
        1:       rready = ~rready;
        default: rready = 1'b0;
      endcase
    end
  end

  // Monitor: compares every R and B handshake against the scoreboard and
  // checks the number of idle cycles before each rvalid.
  initial begin
    rexp_t re;
    bexp_t be;
    int    gap;
    logic  armed;
    gap = 0; armed = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        if (rvalid && armed) begin
          check("r_gap", 32'(gap), 32'(LAT));
          armed = 1'b0;
        end
        if (rvalid && rready) begin
          if (r_q.size() == 0) begin
            n_checks++; n_errs++;
            $display("FAIL r_unexpected: got beat %h expected none", rdata);
          end else begin
            re = r_q.pop_front();
            check("rdata", rdata, re.data);
            check("rresp", 32'(rresp), 32'(re.resp));
            check("rlast", 32'(rlast), 32'(re.last));
            check("rid",   32'(rid),   32'(re.id));
          end
          gap = 0; armed = 1'b1;
        end else if (arvalid && arready) begin
          gap = 0; armed = 1'b1;
        end else if (!rvalid) begin
          gap++;
        end
        if (bvalid && bready) begin
          if (b_q.size() == 0) begin
            n_checks++; n_errs++;
            $display("FAIL b_unexpected: got bresp %0d expected none", bresp);
          end else begin
            be = b_q.pop_front();
            check("bresp", 32'(bresp), 32'(be.resp));
            check("bid",   32'(bid),   32'(be.id));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Issue a write burst: AW and the first W beat together, remaining beats
  // back to back with data d0+i; wlast on beat nbeats-1. Returns the number
  // of cycles the first beat waited for acceptance.
  task automatic write_burst(input logic [31:0] addr, input logic [3:0] id,
                             input logic [7:0] len, input logic [1:0] burst,
                             input int nbeats, input logic [31:0] d0,
                             input logic [3:0] strb, input logic [1:0] exp_resp,
                             output int first_wait);
    bexp_t be;
    int    to;
    be.resp = exp_resp; be.id = id;
    b_q.push_back(be);
    first_wait = 0;
    @(posedge clock); #1;
    awvalid = 1'b1; awaddr = addr; awid = id; awlen = len;
    awsize = 3'd2; awburst = burst;
    for (int i = 0; i < nbeats; i++) begin
      wvalid = 1'b1; wdata = d0 + 32'(i); wstrb = strb; wlast = (i == nbeats - 1);
      to = 0;
      while (to < 50) begin
        @(negedge clock);
        to++;
        if (wready && (!awvalid || awready)) break;
      end
      if (i == 0) first_wait = to;
      if (to >= 50) begin
        n_checks++; n_errs++;
        $display("FAIL w_accept_timeout: beat %0d not accepted, required acceptance", i);
      end
      @(posedge clock); #1;
      awvalid = 1'b0;
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic ar_issue(input logic [31:0] addr, input logic [3:0] id,
                          input logic [7:0] len, input logic [1:0] burst);
    int to;
    @(posedge clock); #1;
    arvalid = 1'b1; araddr = addr; arid = id; arlen = len;
    arsize = 3'd2; arburst = burst;
    to = 0;
    while (to < 50) begin
      @(negedge clock);
      to++;
      if (arready) break;
    end
    if (to >= 50) begin
      n_checks++; n_errs++;
      $display("FAIL ar_accept_timeout: arready low, required high");
    end
    @(posedge clock); #1;
    arvalid = 1'b0;
  endtask

  task automatic drain(input string name);
    int to;
    to = 0;
    while ((r_q.size() != 0 || b_q.size() != 0) && to < 200) begin
      @(negedge clock); #1;
      to++;
    end
    check({name, "_drain"}, 32'(r_q.size() + b_q.size()), 32'd0);
    r_q.delete();
    b_q.delete();
  endtask

  initial begin
    int w;
    int to;
    reset = 1'b0;
    awvalid = 1'b0; awaddr = '0; awid = '0; awlen = '0; awsize = '0; awburst = '0;
    wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0;
    bready = 1'b1;
    arvalid = 1'b0; araddr = '0; arid = '0; arlen = '0; arsize = '0; arburst = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rlast",  32'(rlast),  32'd0);
    check("rst_bresp",  32'(bresp),  32'd0);
    check("rst_rresp",  32'(rresp),  32'd0);
    check("rst_bid",    32'(bid),    32'd0);
    check("rst_rid",    32'(rid),    32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_awready", 32'(awready), 32'd1);

    // Single word write with AW+W in one cycle, then read it back.
    write_burst(32'h8000_0010, 4'd3, 8'd0, 2'b01, 1, 32'hDEAD_BEEF, 4'hF, 2'b00, w);
    check("aw_w_same_cycle", 32'(w), 32'd1);
    drain("single_write");
    push_r(32'hDEAD_BEEF, 2'b00, 1'b1, 4'd5);
    ar_issue(32'h8000_0010, 4'd5, 8'd0, 2'b01);
    drain("single_read");

    // Byte-lane write: lane 1 of the word at 0x10 becomes 0xAA.
    write_burst(32'h8000_0011, 4'd1, 8'd0, 2'b01, 1, 32'h0000_AA00, 4'b0010, 2'b00, w);
    drain("byte_write");
    push_r(32'hDEAD_AAEF, 2'b00, 1'b1, 4'd2);
    ar_issue(32'h8000_0010, 4'd2, 8'd0, 2'b01);
    drain("byte_read");

    // INCR write burst words 0..3, then INCR read burst with toggling rready.
    write_burst(32'h8000_0000, 4'd7, 8'd3, 2'b01, 4, 32'hA5A5_0000, 4'hF, 2'b00, w);
    drain("incr_write");
    rr_mode = 1;
    push_r(32'hA5A5_0000, 2'b00, 1'b0, 4'd9);
    push_r(32'hA5A5_0001, 2'b00, 1'b0, 4'd9);
    push_r(32'hA5A5_0002, 2'b00, 1'b0, 4'd9);
    push_r(32'hA5A5_0003, 2'b00, 1'b1, 4'd9);
    ar_issue(32'h8000_0000, 4'd9, 8'd3, 2'b01);
    drain("incr_read");
    rr_mode = 0;

    // Unmapped read and write; the write must not alias into word 0.
    push_r(32'h0, 2'b10, 1'b1, 4'd2);
    ar_issue(32'h0200_0000, 4'd2, 8'd0, 2'b01);
    drain("unmapped_read");
    write_burst(32'h0200_0000, 4'hB, 8'd0, 2'b01, 1, 32'h1234_5678, 4'hF, 2'b10, w);
    drain("unmapped_write");
    push_r(32'hA5A5_0000, 2'b00, 1'b1, 4'hC);
    ar_issue(32'h8000_0000, 4'hC, 8'd0, 2'b01);
    drain("unmapped_nochange");

    // Early wlast: awlen=2 but only two beats; third word keeps old data.
    write_burst(32'h8000_0028, 4'd0, 8'd0, 2'b01, 1, 32'h3333_3333, 4'hF, 2'b00, w);
    drain("preload");
    write_burst(32'h8000_0020, 4'd8, 8'd2, 2'b01, 2, 32'h0C0C_0000, 4'hF, 2'b10, w);
    drain("short_write");
    push_r(32'h0C0C_0000, 2'b00, 1'b0, 4'hA);
    push_r(32'h0C0C_0001, 2'b00, 1'b0, 4'hA);
    push_r(32'h3333_3333, 2'b00, 1'b1, 4'hA);
    ar_issue(32'h8000_0020, 4'hA, 8'd2, 2'b01);
    drain("short_read");

    // WRAP burst: every beat errors. FIXED burst: same word twice.
    push_r(32'h0, 2'b10, 1'b0, 4'hD);
    push_r(32'h0, 2'b10, 1'b1, 4'hD);
    ar_issue(32'h8000_0000, 4'hD, 8'd1, 2'b10);
    drain("wrap_read");
    push_r(32'hDEAD_AAEF, 2'b00, 1'b0, 4'hE);
    push_r(32'hDEAD_AAEF, 2'b00, 1'b1, 4'hE);
    ar_issue(32'h8000_0010, 4'hE, 8'd1, 2'b00);
    drain("fixed_read");

    // Reset in the middle of a read burst while beat 2 is presented.
    push_r(32'hA5A5_0000, 2'b00, 1'b0, 4'd4);
    ar_issue(32'h8000_0000, 4'd4, 8'd3, 2'b01);
    to = 0;
    while (r_q.size() != 0 && to < 100) begin
      @(negedge clock); #1;
      to++;
    end
    check("mid_beat1_seen", 32'(r_q.size()), 32'd0);
    rr_mode = 2;
    to = 0;
    while (to < 50) begin
      @(negedge clock);
      to++;
      if (rvalid) break;
    end
    check("mid_beat2_valid", 32'(rvalid), 32'd1);
    @(posedge clock); #3;
    reset = 1'b0;
    #1;
    check("async_rvalid", 32'(rvalid), 32'd0);
    check("async_rlast",  32'(rlast),  32'd0);
    r_q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    rr_mode = 0;
    @(negedge clock);
    check("post_rst_arready", 32'(arready), 32'd1);
    push_r(32'hDEAD_AAEF, 2'b00, 1'b1, 4'd6);
    ar_issue(32'h8000_0010, 4'd6, 8'd0, 2'b01);
    drain("post_rst_read");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
